// File: rtl/wci_pkg.sv
// wci_pkg: shared encodings for the WCI::OCP control/configuration target.
//   - MCmd request codes, SResp response codes
//   - worker control states and control-operation opcodes
//   - request-FSM states and the captured request record
//   - fixed response words for control operations
//   - be_mask(): expands 4 byte enables into a 32-bit lane mask
package wci_pkg;

    localparam logic [2:0] MCMD_IDLE = 3'd0;
    localparam logic [2:0] MCMD_WR   = 3'd1;
    localparam logic [2:0] MCMD_RD   = 3'd2;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'd0,
        SRESP_DVA  = 2'd1,
        SRESP_FAIL = 2'd2,
        SRESP_ERR  = 2'd3
    } sresp_e;

    typedef enum logic [1:0] {
        ST_EXISTS      = 2'd0,
        ST_INITIALIZED = 2'd1,
        ST_OPERATING   = 2'd2,
        ST_SUSPENDED   = 2'd3
    } ctl_state_e;

    typedef enum logic [2:0] {
        OP_INITIALIZE  = 3'd0,
        OP_START       = 3'd1,
        OP_STOP        = 3'd2,
        OP_RELEASE     = 3'd3,
        OP_TEST        = 3'd4,
        OP_BEFOREQUERY = 3'd5,
        OP_AFTERCONFIG = 3'd6,
        OP_ILLEGAL     = 3'd7
    } ctl_op_e;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_RESP = 1'b1
    } req_state_e;

    typedef struct packed {
        logic        is_wr;
        logic        space;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] data;
    } wci_req_t;

    localparam logic [31:0] WCI_OK  = 32'hC0DE_4201;
    localparam logic [31:0] WCI_ERR = 32'hC0DE_4202;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wci_cfg_regfile.sv
// wci_cfg_regfile: NREGS x 32-bit configuration property registers.
//   clk/rst  : clock, asynchronous active-high clear
//   clr      : synchronous clear
//   we       : write strobe; idx selects the register, be the byte lanes
//   wdata    : write data
//   rdata    : combinational read of register idx (0 for idx >= NREGS)
module wci_cfg_regfile
    import wci_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        we,
    input  logic [3:0]  idx,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem_q [NREGS];
    logic [31:0] mem_d [NREGS];

    // Byte-lane merge of the write data into the selected register.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = (we && (idx == 4'(i)))
                     ? ((mem_q[i] & ~be_mask(be)) | (wdata & be_mask(be)))
                     : mem_q[i];
        end
    end

    // Read mux.
    always_comb begin
        rdata = 32'd0;
        for (int i = 0; i < NREGS; i++) begin
            rdata = (idx == 4'(i)) ? mem_q[i] : rdata;
        end
    end

    // Register storage with async and sync clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= 32'd0;
        end else if (clr) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/wci_ocp_target_ctl.sv
// wci_ocp_target_ctl: WCI::OCP target for an OCPI worker control port.
//   CLK/RST            : clock, asynchronous active-high reset
//   wciS0_MReset_n     : synchronous active-low link reset
//   wciS0_M*           : request (cmd, address space, byte enables, addr, data)
//   wciS0_SResp/SData  : one-cycle response, one cycle after accept
//   wciS0_SThreadBusy  : high for the cycle after an accept and during reset
//   wciS0_SFlag        : {present, sticky attention}
//   ctl_state          : worker control state
//   cfg_wr/cfg_idx     : pulse + index on each accepted config write
module wci_ocp_target_ctl
    import wci_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wciS0_MReset_n,
    input  logic [2:0]  wciS0_MCmd,
    input  logic        wciS0_MAddrSpace,
    input  logic [3:0]  wciS0_MByteEn,
    input  logic [19:0] wciS0_MAddr,
    input  logic [31:0] wciS0_MData,
    output logic [1:0]  wciS0_SResp,
    output logic [31:0] wciS0_SData,
    output logic        wciS0_SThreadBusy,
    output logic [1:0]  wciS0_SFlag,
    input  logic [1:0]  wciS0_MFlag,
    output logic [2:0]  ctl_state,
    output logic        cfg_wr,
    output logic [3:0]  cfg_idx
);

    localparam logic [4:0] NREGS_W = 5'(NREGS);

    req_state_e  req_state_q, req_state_d;
    wci_req_t    req_q, req_d;
    logic        busy_q, busy_d;
    ctl_state_e  ctl_q, ctl_d;
    logic        attn_q, attn_d;
    sresp_e      resp_q, resp_d;
    logic [31:0] sdata_q, sdata_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic [3:0]  cfg_idx_q, cfg_idx_d;

    logic        soft_rst_s;
    logic        accept_s;
    logic        cfg_in_range_s;
    logic        reg_we_s;
    logic [31:0] reg_rdata_s;
    logic        op_legal_s;
    logic        op_clr_attn_s;
    ctl_state_e  op_next_s;
    logic        unused_s;

    assign soft_rst_s = ~wciS0_MReset_n;
    assign accept_s   = (req_state_q == REQ_IDLE) && !busy_q &&
                        ((wciS0_MCmd == MCMD_WR) || (wciS0_MCmd == MCMD_RD));
    assign cfg_in_range_s = ({1'b0, req_q.addr[5:2]} < NREGS_W) &&
                            (req_q.addr[19:6] == 14'd0);
    assign unused_s = ^{wciS0_MFlag, req_q.addr[1:0]};

    wci_cfg_regfile #(.NREGS(NREGS)) u_regs (
        .clk   (CLK),
        .rst   (RST),
        .clr   (soft_rst_s),
        .we    (reg_we_s),
        .idx   (req_q.addr[5:2]),
        .be    (req_q.be),
        .wdata (req_q.data),
        .rdata (reg_rdata_s)
    );

    // State register: request FSM, control FSM and response flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_state_q <= REQ_IDLE;
            req_q       <= '0;
            busy_q      <= 1'b1;
            ctl_q       <= ST_EXISTS;
            attn_q      <= 1'b0;
            resp_q      <= SRESP_NULL;
            sdata_q     <= 32'd0;
            cfg_wr_q    <= 1'b0;
            cfg_idx_q   <= 4'd0;
        end else if (soft_rst_s) begin
            req_state_q <= REQ_IDLE;
            req_q       <= '0;
            busy_q      <= 1'b1;
            ctl_q       <= ST_EXISTS;
            attn_q      <= 1'b0;
            resp_q      <= SRESP_NULL;
            sdata_q     <= 32'd0;
            cfg_wr_q    <= 1'b0;
            cfg_idx_q   <= 4'd0;
        end else begin
            req_state_q <= req_state_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            ctl_q       <= ctl_d;
            attn_q      <= attn_d;
            resp_q      <= resp_d;
            sdata_q     <= sdata_d;
            cfg_wr_q    <= cfg_wr_d;
            cfg_idx_q   <= cfg_idx_d;
        end
    end

    // Request FSM next state: capture on accept, respond on the following edge.
    always_comb begin
        req_state_d = req_state_q;
        req_d       = req_q;
        busy_d      = 1'b0;
        case (req_state_q)
            REQ_IDLE: begin
                if (accept_s) begin
                    req_state_d = REQ_RESP;
                    busy_d      = 1'b1;
                    req_d.is_wr = (wciS0_MCmd == MCMD_WR);
                    req_d.space = wciS0_MAddrSpace;
                    req_d.be    = wciS0_MByteEn;
                    req_d.addr  = wciS0_MAddr;
                    req_d.data  = wciS0_MData;
                end else begin
                    req_state_d = REQ_IDLE;
                end
            end
            REQ_RESP: req_state_d = REQ_IDLE;
            default:  req_state_d = REQ_IDLE;
        endcase
    end

    // Control-operation legality and target state.
    always_comb begin
        op_legal_s    = 1'b0;
        op_clr_attn_s = 1'b0;
        op_next_s     = ctl_q;
        case (ctl_op_e'(req_q.addr[4:2]))
            OP_INITIALIZE: begin
                op_legal_s    = (ctl_q == ST_EXISTS);
                op_clr_attn_s = (ctl_q == ST_EXISTS);
                op_next_s     = ST_INITIALIZED;
            end
            OP_START: begin
                op_legal_s = (ctl_q == ST_INITIALIZED) || (ctl_q == ST_SUSPENDED);
                op_next_s  = ST_OPERATING;
            end
            OP_STOP: begin
                op_legal_s = (ctl_q == ST_OPERATING);
                op_next_s  = ST_SUSPENDED;
            end
            OP_RELEASE: begin
                op_legal_s = (ctl_q != ST_EXISTS);
                op_next_s  = ST_EXISTS;
            end
            OP_TEST, OP_BEFOREQUERY, OP_AFTERCONFIG: op_legal_s = (ctl_q != ST_EXISTS);
            default: op_legal_s = 1'b0;
        endcase
    end

    // Response, control-state, attention and config-write outputs.
    always_comb begin
        ctl_d     = ctl_q;
        attn_d    = attn_q;
        resp_d    = SRESP_NULL;
        sdata_d   = 32'd0;
        cfg_wr_d  = 1'b0;
        cfg_idx_d = cfg_idx_q;
        reg_we_s  = 1'b0;
        if (req_state_q == REQ_RESP) begin
            if (!req_q.space) begin
                if (req_q.is_wr) begin
                    resp_d = SRESP_ERR;
                end else if (op_legal_s) begin
                    resp_d  = SRESP_DVA;
                    sdata_d = WCI_OK;
                    ctl_d   = op_next_s;
                    attn_d  = op_clr_attn_s ? 1'b0 : attn_q;
                end else begin
                    resp_d  = SRESP_ERR;
                    sdata_d = WCI_ERR;
                    attn_d  = 1'b1;
                end
            end else if (!cfg_in_range_s) begin
                resp_d = SRESP_ERR;
                attn_d = 1'b1;
            end else if (req_q.is_wr) begin
                if (ctl_q == ST_EXISTS) begin
                    resp_d = SRESP_ERR;
                end else begin
                    resp_d    = SRESP_DVA;
                    reg_we_s  = 1'b1;
                    cfg_wr_d  = 1'b1;
                    cfg_idx_d = req_q.addr[5:2];
                end
            end else begin
                // Reads return the stored value in every state, including
                // EXISTS after a RELEASE (registers survive RELEASE).
                resp_d  = SRESP_DVA;
                sdata_d = reg_rdata_s;
            end
        end else begin
            resp_d = SRESP_NULL;
        end
    end

    assign wciS0_SResp       = resp_q;
    assign wciS0_SData       = sdata_q;
    assign wciS0_SThreadBusy = busy_q;
    assign wciS0_SFlag       = {1'b1, attn_q};
    assign ctl_state         = {1'b0, ctl_q};
    assign cfg_wr            = cfg_wr_q;
    assign cfg_idx           = cfg_idx_q;

endmodule

// File: tb/tb_wci_ocp_target_ctl.sv
module tb_wci_ocp_target_ctl;

    localparam int NREGS = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MReset_n = 1'b1;
    logic [2:0]  MCmd = 3'd0;
    logic        MSpace = 1'b0;
    logic [3:0]  MBe = 4'd0;
    logic [19:0] MAddr = 20'd0;
    logic [31:0] MData = 32'd0;
    logic [1:0]  MFlag = 2'd0;
    logic [1:0]  SResp;
    logic [31:0] SData;
    logic        SBusy;
    logic [1:0]  SFlag;
    logic [2:0]  ctl_state;
    logic        cfg_wr;
    logic [3:0]  cfg_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    wci_ocp_target_ctl #(.NREGS(NREGS)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .wciS0_MReset_n    (MReset_n),
        .wciS0_MCmd        (MCmd),
        .wciS0_MAddrSpace  (MSpace),
        .wciS0_MByteEn     (MBe),
        .wciS0_MAddr       (MAddr),
        .wciS0_MData       (MData),
        .wciS0_SResp       (SResp),
        .wciS0_SData       (SData),
        .wciS0_SThreadBusy (SBusy),
        .wciS0_SFlag       (SFlag),
        .wciS0_MFlag       (MFlag),
        .ctl_state         (ctl_state),
        .cfg_wr            (cfg_wr),
        .cfg_idx           (cfg_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = 0;       // 0 EXISTS, 1 INITIALIZED, 2 OPERATING, 3 SUSPENDED
    bit          m_attn = 1'b0;
    logic [31:0] m_regs [NREGS];
    bit          m_busy = 1'b1;
    bit          m_pend = 1'b0;
    bit          p_wr, p_space;
    logic [3:0]  p_be;
    logic [19:0] p_addr;
    logic [31:0] p_data;
    logic [1:0]  e_resp = 2'd0;
    logic [31:0] e_data = 32'd0;
    logic        e_cfg_wr = 1'b0;
    logic [3:0]  e_cfg_idx = 4'd0;

    task automatic m_exec();
        int  ix;
        int  op;
        bit  ok;
        int  nxt;
        ix = int'(p_addr[5:2]);
        e_resp = 2'd3;
        e_data = 32'd0;
        if (!p_space) begin
            if (!p_wr) begin
                op  = int'(p_addr[4:2]);
                ok  = 1'b0;
                nxt = m_state;
                case (op)
                    0: begin ok = (m_state == 0); nxt = 1; end
                    1: begin ok = (m_state == 1 || m_state == 3); nxt = 2; end
                    2: begin ok = (m_state == 2); nxt = 3; end
                    3: begin ok = (m_state != 0); nxt = 0; end
                    4, 5, 6: ok = (m_state != 0);
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    e_resp  = 2'd1;
                    e_data  = 32'hC0DE_4201;
                    if (op == 0) m_attn = 1'b0;
                    m_state = nxt;
                end else begin
                    e_data = 32'hC0DE_4202;
                    m_attn = 1'b1;
                end
            end
        end else if (p_addr[19:6] != 14'd0 || ix >= NREGS) begin
            m_attn = 1'b1;
        end else if (p_wr) begin
            if (m_state != 0) begin
                for (int k = 0; k < 4; k++)
                    if (p_be[k]) m_regs[ix][8*k +: 8] = p_data[8*k +: 8];
                e_resp    = 2'd1;
                e_cfg_wr  = 1'b1;
                e_cfg_idx = p_addr[5:2];
            end
        end else begin
            e_resp = 2'd1;
            e_data = m_regs[ix];
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
        forever begin
            @(posedge CLK or posedge RST);
            if (RST || !MReset_n) begin
                m_state = 0; m_attn = 1'b0; m_busy = 1'b1; m_pend = 1'b0;
                e_resp = 2'd0; e_data = 32'd0; e_cfg_wr = 1'b0; e_cfg_idx = 4'd0;
                for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
            end else begin
                e_resp = 2'd0; e_data = 32'd0; e_cfg_wr = 1'b0;
                if (m_pend) begin
                    m_exec();
                    m_pend = 1'b0;
                    m_busy = 1'b0;
                end else if ((MCmd == 3'd1 || MCmd == 3'd2) && !m_busy) begin
                    p_wr = (MCmd == 3'd1); p_space = MSpace; p_be = MBe;
                    p_addr = MAddr; p_data = MData;
                    m_pend = 1'b1;
                    m_busy = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge CLK);
            check("sresp", 32'(SResp), 32'(e_resp));
            check("sdata", SData, e_data);
            check("busy", 32'(SBusy), 32'(m_busy));
            check("sflag", 32'(SFlag), {30'd0, 1'b1, m_attn});
            check("ctl_state", 32'(ctl_state), 32'(m_state));
            check("cfg_wr", 32'(cfg_wr), 32'(e_cfg_wr));
            check("cfg_idx", 32'(cfg_idx), 32'(e_cfg_idx));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [2:0] cmd, input logic sp, input logic [19:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output logic [1:0] r, output logic [31:0] rd,
                         output logic cw, output logic [3:0] ci);
        int w;
        w = 0;
        @(posedge CLK); #3;
        while (SBusy && w < 10) begin
            @(posedge CLK); #3;
            w++;
        end
        check("busy_wait", 32'(SBusy), 32'd0);
        MCmd = cmd; MSpace = sp; MAddr = a; MData = d; MBe = be;
        @(posedge CLK); #3;
        MCmd = 3'd0;
        @(posedge CLK); #2;
        r = SResp; rd = SData; cw = cfg_wr; ci = cfg_idx;
    endtask

    logic [1:0]  r;
    logic [31:0] rd;
    logic        cw;
    logic [3:0]  ci;
    int          cnt;
    int          sel;

    initial begin
        // reset
        repeat (3) @(posedge CLK);
        #3;
        check("rst_busy", 32'(SBusy), 32'd1);
        check("rst_sflag", 32'(SFlag), 32'd2);
        RST = 1'b0;
        @(posedge CLK); #2;
        check("rel_busy", 32'(SBusy), 32'd0);
        check("rel_ctl", 32'(ctl_state), 32'd0);

        // START from EXISTS is illegal
        issue(3'd2, 1'b0, 20'h4, 32'd0, 4'hF, r, rd, cw, ci);
        check("start_ex_resp", 32'(r), 32'd3);
        check("start_ex_data", rd, 32'hC0DE_4202);
        check("start_ex_sflag", 32'(SFlag), 32'd3);

        // INITIALIZE
        issue(3'd2, 1'b0, 20'h0, 32'd0, 4'hF, r, rd, cw, ci);
        check("init_resp", 32'(r), 32'd1);
        check("init_data", rd, 32'hC0DE_4201);
        check("init_ctl", 32'(ctl_state), 32'd1);
        check("init_sflag", 32'(SFlag), 32'd2);

        // byte-enabled config write then read
        issue(3'd1, 1'b1, 20'h8, 32'hAABB_CCDD, 4'b0101, r, rd, cw, ci);
        check("wr_resp", 32'(r), 32'd1);
        check("wr_data", rd, 32'd0);
        check("wr_pulse", 32'(cw), 32'd1);
        check("wr_idx", 32'(ci), 32'd2);
        issue(3'd2, 1'b1, 20'h8, 32'd0, 4'hF, r, rd, cw, ci);
        check("rd_resp", 32'(r), 32'd1);
        check("rd_data", rd, 32'h00BB_00DD);

        // START
        issue(3'd2, 1'b0, 20'h4, 32'd0, 4'hF, r, rd, cw, ci);
        check("start_resp", 32'(r), 32'd1);
        check("start_ctl", 32'(ctl_state), 32'd2);

        // out-of-range config read
        issue(3'd2, 1'b1, 20'h40, 32'd0, 4'hF, r, rd, cw, ci);
        check("oor_resp", 32'(r), 32'd3);
        check("oor_data", rd, 32'd0);
        check("oor_sflag", 32'(SFlag), 32'd3);

        // RELEASE, then config write in EXISTS is refused
        issue(3'd2, 1'b0, 20'hC, 32'd0, 4'hF, r, rd, cw, ci);
        check("rel_ctl_op", 32'(ctl_state), 32'd0);
        issue(3'd1, 1'b1, 20'h10, 32'h1234_5678, 4'hF, r, rd, cw, ci);
        check("wr_ex_resp", 32'(r), 32'd3);
        check("wr_ex_pulse", 32'(cw), 32'd0);
        issue(3'd2, 1'b1, 20'h10, 32'd0, 4'hF, r, rd, cw, ci);
        check("rd_ex_resp", 32'(r), 32'd1);
        check("rd_ex_data", rd, 32'd0);

        // RD held for 3 edges: two accepts, two one-cycle responses
        @(posedge CLK); #3;
        MCmd = 3'd2; MSpace = 1'b1; MAddr = 20'h8;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #3;
            if (c == 2) MCmd = 3'd0;
            #2;
            if (SResp != 2'd0) cnt++;
        end
        check("hold_resps", 32'(cnt), 32'd2);

        // link reset right after accepting a config write
        issue(3'd2, 1'b0, 20'h0, 32'd0, 4'hF, r, rd, cw, ci);
        @(posedge CLK); #3;
        MCmd = 3'd1; MSpace = 1'b1; MAddr = 20'hC; MData = 32'hDEAD_BEEF; MBe = 4'hF;
        @(posedge CLK); #3;
        MCmd = 3'd0;
        MReset_n = 1'b0;
        @(posedge CLK); #2;
        check("mrst_busy", 32'(SBusy), 32'd1);
        #1;
        MReset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #2;
            if (SResp != 2'd0 || cfg_wr) cnt++;
        end
        check("mrst_noresp", 32'(cnt), 32'd0);
        check("mrst_ctl", 32'(ctl_state), 32'd0);
        issue(3'd2, 1'b1, 20'hC, 32'd0, 4'hF, r, rd, cw, ci);
        check("mrst_rd", rd, 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            @(posedge CLK); #3;
            MReset_n = ($urandom_range(0, 99) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 4)       MCmd = 3'd2;
            else if (sel < 7)  MCmd = 3'd1;
            else if (sel == 8) MCmd = 3'($urandom_range(3, 7));
            else               MCmd = 3'd0;
            MSpace = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) MAddr = 20'($urandom);
            else                           MAddr = 20'($urandom_range(0, 63));
            MData = $urandom;
            MBe   = 4'($urandom_range(0, 15));
            MFlag = 2'($urandom_range(0, 3));
        end
        @(posedge CLK); #3;
        MCmd = 3'd0;
        MReset_n = 1'b1;
        repeat (4) @(posedge CLK);
        #7;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wci_ocp_target_ctl.md
# wci_ocp_target_ctl

Hand-written WCI::OCP target (responder) for the control/configuration port of an OCPI worker. It accepts requests from a WCI initiator on the `wciS0_` signal group and owns the worker control-state machine. It also holds a 16-entry configuration-property register file and returns exactly one response per request. It is the completion end of the WCI0 link, the peer of the initiator BFM, and is observable by the WCI monitor.

## Interface
- `NREGS`, 16: number of 32-bit config properties; must be a power of 2, ≤ 16.
- `CLK`  in  1  single clock; all WCI signals are sampled on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `wciS0_MReset_n`  in  1  WCI link reset, active-low, sampled synchronously; same effect as `RST` but synchronous.
- `wciS0_MCmd`  in  3  0 = IDLE, 1 = WR, 2 = RD; other codes are treated as IDLE.
- `wciS0_MAddrSpace`  in  1  0 = control, 1 = config.
- `wciS0_MByteEn`  in  4  write byte lanes.
- `wciS0_MAddr`  in  20  byte address.
- `wciS0_MData`  in  32  write data.
- `wciS0_SResp`  out  2  0 = NULL, 1 = DVA, 2 = FAIL, 3 = ERR.
- `wciS0_SData`  out  32  response data.
- `wciS0_SThreadBusy`  out  1  target cannot accept a request.
- `wciS0_SFlag`  out  2  [0] attention (sticky error), [1] present.
- `wciS0_MFlag`  in  2  unused; any value is tolerated.
- `ctl_state`  out  3  current control state.
- `cfg_wr`  out  1  one-cycle pulse on each accepted config write.
- `cfg_idx`  out  4  register index of that write.

## Operation
- States: EXISTS = 0, INITIALIZED = 1, OPERATING = 2, SUSPENDED = 3. Reset state is EXISTS.
- Control ops are control-space RDs; the opcode is `MAddr[4:2]`:
  - INITIALIZE (0): EXISTS → INITIALIZED.
  - START (1): INITIALIZED or SUSPENDED → OPERATING.
  - STOP (2): OPERATING → SUSPENDED.
  - RELEASE (3): any state except EXISTS → EXISTS.
  - TEST (4), BEFOREQUERY (5), AFTERCONFIG (6): legal in any state except EXISTS; no state change.
  - Opcode 7: illegal.
- Legal control op: response DVA, SData = 0xC0DE_4201.
- Illegal op or illegal transition: response ERR, SData = 0xC0DE_4202, state unchanged, SFlag[0] set.
- Control-space WR: response ERR, SData = 0.
- Config access: index = `MAddr[5:2]`. An access is out of range if index ≥ `NREGS` or `MAddr[19:6]` ≠ 0; response ERR, SData = 0, SFlag[0] set.
- Config WR:
  - Legal only when state ≠ EXISTS; otherwise ERR with no update.
  - On a legal write, only lanes with `MByteEn[k]` = 1 are updated; response DVA, SData = 0; `cfg_wr`/`cfg_idx` pulse.
- Config RD: DVA with the register value, allowed in any state. In EXISTS it reads the reset value 0.
- RELEASE does not clear the registers. Only `RST` or `MReset_n` clears them.
- SFlag[0] is cleared only by reset or a successful INITIALIZE.

## Timing
- Request accept: at edge N when `MCmd` ∈ {1, 2} and `SThreadBusy` = 0. All request fields are captured at N.
- `SThreadBusy` is 1 after N and 0 after N+1. Requests presented while busy are ignored, not queued.
- Response: `SResp` ≠ NULL for exactly the one cycle following edge N+1. Outside that cycle `SResp` = NULL and `SData` = 0.
- Response latency is 1 cycle after accept. Back-to-back issue rate is one request per 2 cycles.
- State update, register update and `cfg_wr` all take effect at edge N+1, coincident with the response.
- Reset values (both resets):
  - `SResp` = 0, `SData` = 0.
  - `SThreadBusy` = 1 while either reset is asserted, then 0 from the first edge after release.
  - `SFlag` = 2'b10; SFlag[1] stays 1 at all times out of reset.
  - `ctl_state` = 0, `cfg_wr` = 0, `cfg_idx` = 0, all registers = 0.
- Reset mid-operation: any pending response is dropped and no DVA/ERR is emitted afterwards.

## Structure
- Package `wci_pkg` holds:
  - MCmd, SResp, control-state and opcode encodings.
  - `WCI_OK` = 0xC0DE_4201, `WCI_ERR` = 0xC0DE_4202.
- Sub-module `wci_cfg_regfile`: `NREGS`×32 registers, byte-enabled write, combinational read, async/sync clear.
- Top level: 2-state request FSM (IDLE, RESP), control FSM, response registers.

## Test plan
- Reset release → `SThreadBusy` 1→0, `SFlag` = 2'b10, `ctl_state` = 0. START (RD, space 0, addr 0x04) → ERR, 0xC0DE_4202, `SFlag` = 2'b11.
- INITIALIZE (0x00) then START (0x04) → DVA 0xC0DE_4201 each, `ctl_state` 1 then 2, `SFlag[0]` cleared.
- While INITIALIZED: WR space 1, addr 0x08, data 0xAABBCCDD, BE 4'b0101 over reg = 0 → `cfg_wr` pulse with `cfg_idx` = 2; RD returns 0x00BB00DD.
- Config RD at addr 0x40 → ERR, data 0. Config WR while in EXISTS → ERR, and a RD of that register returns 0.
- Initiator holds `MCmd` = RD for 3 cycles → exactly 2 accepts, each response one cycle wide.
- `MReset_n` pulsed low on the edge after accepting a config WR → no response, register unchanged, `ctl_state` = 0.
